// File: rtl/bgen_sched_pkg.sv
// -----------------------------------------------------------------------------
// bgen_sched_pkg
// Shared definitions for the bgen_sched tick-divider scheduler.
//   - state_t       : scheduler FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - DEF_*         : default parameter widths
//   - MAX_NREQ      : largest supported requester count
//   - rr_next()     : round-robin winner search starting after the last winner
// -----------------------------------------------------------------------------
package bgen_sched_pkg;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_BITWIDTH = 8;
   localparam int DEF_NTICKS_W = 8;
   localparam int MAX_NREQ     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns the first set bit of req_v scanning from last+1 upward and
   // wrapping at nreq. When no bit is set the previous winner is returned;
   // callers only use the result when at least one request is pending.
   function automatic logic [2:0] rr_next(input logic [7:0] req_v,
                                          input logic [2:0] last,
                                          input int         nreq);
      logic [2:0] pick;
      logic       found;
      int         idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= MAX_NREQ; i++) begin
         if (i <= nreq && !found) begin
            idx = int'(last) + i;
            if (idx >= nreq) idx = idx - nreq;
            if (req_v[idx[2:0]]) begin
               pick  = idx[2:0];
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/bgen_sched_tick.sv
// -----------------------------------------------------------------------------
// bgen_tick
// Programmable tick divider. Counts 0..final_value while en is high and
// raises tick in the cycle the count equals final_value; the count wraps to 0
// on the following edge. clr returns the count to 0. When en is low the
// count is frozen and tick stays low.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   clr          in   synchronous count clear
//   en           in   count enable
//   final_value  in   [BITWIDTH] terminal count (period = final_value+1)
//   tick         out  one-cycle tick at terminal count
// -----------------------------------------------------------------------------
module bgen_tick #(
   parameter int BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                en,
   input  logic [BITWIDTH-1:0] final_value,
   output logic                tick
);

   logic [BITWIDTH-1:0] cnt_q;

   assign tick = en && (cnt_q == final_value);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         if (tick) cnt_q <= '0;
         else      cnt_q <= cnt_q + BITWIDTH'(1);
      end
   end

endmodule

// File: rtl/bgen_sched.sv
// -----------------------------------------------------------------------------
// bgen_sched
// Shares one tick divider among NREQ requesters. Each requester asks for a
// delay of n_ticks divider periods of (final_value+1) cycles; the scheduler
// grants round-robin, runs the divider, and pulses done to the winner.
//
// Optional build macro: BGEN_SCHED_ABORT_EN
//   defined   - dropping req of the granted requester during RUN returns to
//               IDLE without a done pulse.
//   undefined - a dropped req is ignored and the service completes.
//
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   req            in   [NREQ] level service requests
//   final_value_i  in   [NREQ*BITWIDTH] per-requester divider final value
//   n_ticks_i      in   [NREQ*NTICKS_W] per-requester tick count
//   gnt            out  [NREQ] one-hot grant, high for the whole service
//   done           out  [NREQ] one-cycle completion pulse
//   busy           out  high in RUN and DONE
//   tick           out  divider tick (observation)
// -----------------------------------------------------------------------------
module bgen_sched
   import bgen_sched_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int BITWIDTH = DEF_BITWIDTH,
   parameter int NTICKS_W = DEF_NTICKS_W
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*BITWIDTH-1:0] final_value_i,
   input  logic [NREQ*NTICKS_W-1:0] n_ticks_i,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          done,
   output logic                     busy,
   output logic                     tick
);

   state_t              state_q, state_d;
   logic [2:0]          rr_last_q;
   logic [NREQ-1:0]     gnt_q;
   logic [BITWIDTH-1:0] fv_q;
   logic [NTICKS_W-1:0] rem_q;

   logic [7:0]          req_ext;
   logic                any_req;
   logic [2:0]          pick;
   logic [BITWIDTH-1:0] fv_sel;
   logic [NTICKS_W-1:0] n_sel;
   logic [NREQ-1:0]     gnt_sel;

   logic                grant;
   logic                div_clr;
   logic                div_en;
   logic                div_tick;

   assign req_ext = 8'(req);
   assign any_req = |req;
   assign pick    = rr_next(req_ext, rr_last_q, NREQ);

   // Constant-index mux keeps the selects free of variable-width indexing.
   always_comb begin
      fv_sel  = '0;
      n_sel   = '0;
      gnt_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick == 3'(i)) begin
            fv_sel     = final_value_i[i*BITWIDTH +: BITWIDTH];
            n_sel      = n_ticks_i[i*NTICKS_W +: NTICKS_W];
            gnt_sel[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      div_clr = 1'b0;
      div_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               grant   = 1'b1;
               div_clr = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            // The cycle that finds rem_q already exhausted is spent with the
            // divider frozen, so no stray tick appears before DONE.
`ifdef BGEN_SCHED_ABORT_EN
            if ((req & gnt_q) == '0) state_d = IDLE;
            else if (rem_q == '0)    state_d = DONE;
            else                     div_en  = 1'b1;
`else
            if (rem_q == '0) state_d = DONE;
            else             div_en  = 1'b1;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         rr_last_q <= 3'(NREQ - 1);
         gnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            rr_last_q <= pick;
            gnt_q     <= gnt_sel;
         end else if (state_d == IDLE) begin
            gnt_q <= '0;
         end
      end
   end

   // Service parameters are captured only at grant; later input changes
   // have no effect on the running service.
   always_ff @(posedge clk) begin
      if (grant) begin
         fv_q  <= fv_sel;
         rem_q <= n_sel;
      end else if (div_en && div_tick) begin
         rem_q <= rem_q - NTICKS_W'(1);
      end
   end

   bgen_tick #(
      .BITWIDTH (BITWIDTH)
   ) u_tick (
      .clk         (clk),
      .reset_n     (reset_n),
      .clr         (div_clr),
      .en          (div_en),
      .final_value (fv_q),
      .tick        (div_tick)
   );

   assign gnt  = gnt_q;
   assign done = (state_q == DONE) ? gnt_q : '0;
   assign busy = (state_q != IDLE);
   assign tick = div_tick;

endmodule

// File: tb/tb_bgen_sched.sv
module tb_bgen_sched;

   localparam int NREQ     = 4;
   localparam int BITWIDTH = 8;
   localparam int NTICKS_W = 8;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NREQ-1:0]          req;
   logic [NREQ*BITWIDTH-1:0] final_value_i;
   logic [NREQ*NTICKS_W-1:0] n_ticks_i;
   logic [NREQ-1:0]          gnt;
   logic [NREQ-1:0]          done;
   logic                     busy;
   logic                     tick;

   logic [BITWIDTH-1:0] fv [NREQ];
   logic [NTICKS_W-1:0] nt [NREQ];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      final_value_i = '0;
      n_ticks_i     = '0;
      for (int i = 0; i < NREQ; i++) begin
         final_value_i[i*BITWIDTH +: BITWIDTH] = fv[i];
         n_ticks_i[i*NTICKS_W +: NTICKS_W]     = nt[i];
      end
   end

   bgen_sched #(
      .NREQ     (NREQ),
      .BITWIDTH (BITWIDTH),
      .NTICKS_W (NTICKS_W)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req           (req),
      .final_value_i (final_value_i),
      .n_ticks_i     (n_ticks_i),
      .gnt           (gnt),
      .done          (done),
      .busy          (busy),
      .tick          (tick)
   );

   // ---------------------------------------------------------------------
   // Service-level model: a service granted at cycle g with final value F
   // and tick count N lasts L = N*(F+1) RUN cycles plus one frozen RUN cycle,
   // then one DONE cycle. Offset t = cycle - g.
   //   tick  when t < L and (t+1) is a multiple of (F+1)
   //   done  at t == L+1
   // ---------------------------------------------------------------------
   logic m_active = 1'b0;
   int   m_win    = 0;
   int   m_last   = NREQ - 1;
   int   m_f      = 0;
   int   m_n      = 0;
   int   m_t      = 0;

   always @(negedge clk) begin
      logic [NREQ-1:0] e_gnt, e_done;
      logic            e_busy, e_tick;
      int              len, w;
      e_gnt  = '0;
      e_done = '0;
      e_busy = 1'b0;
      e_tick = 1'b0;
      len    = 0;
      if (!reset_n) begin
         m_active = 1'b0;
         m_last   = NREQ - 1;
      end else if (m_active) begin
         len    = m_n * (m_f + 1);
         e_gnt  = NREQ'(1) << m_win;
         e_busy = 1'b1;
         e_tick = (m_t < len) && (((m_t + 1) % (m_f + 1)) == 0);
         e_done = (m_t == len + 1) ? e_gnt : '0;
      end

      n_cmp++;
      if (gnt !== e_gnt) begin
         n_bad++;
         $display("FAIL model gnt t=%0t got=%b want=%b", $time, gnt, e_gnt);
      end
      n_cmp++;
      if (done !== e_done) begin
         n_bad++;
         $display("FAIL model done t=%0t got=%b want=%b", $time, done, e_done);
      end
      n_cmp++;
      if (busy !== e_busy) begin
         n_bad++;
         $display("FAIL model busy t=%0t got=%b want=%b", $time, busy, e_busy);
      end
      n_cmp++;
      if (tick !== e_tick) begin
         n_bad++;
         $display("FAIL model tick t=%0t got=%b want=%b", $time, tick, e_tick);
      end
      n_cmp++;
      if (!$onehot0(gnt) || !$onehot0(done)) begin
         n_bad++;
         $display("FAIL onehot t=%0t gnt=%b done=%b want one-hot-or-zero", $time, gnt, done);
      end

      if (reset_n) begin
         if (m_active) begin
            if (m_t == len + 1) m_active = 1'b0;
`ifdef BGEN_SCHED_ABORT_EN
            else if (m_t <= len && !req[m_win]) m_active = 1'b0;
`endif
            else m_t++;
         end else if (|req) begin
            w = m_last;
            for (int i = 1; i <= NREQ; i++) begin
               if (req[(m_last + i) % NREQ]) begin
                  w = (m_last + i) % NREQ;
                  break;
               end
            end
            m_win    = w;
            m_last   = w;
            m_f      = int'(fv[w]);
            m_n      = int'(nt[w]);
            m_t      = 0;
            m_active = 1'b1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '0;
      for (int i = 0; i < NREQ; i++) begin
         fv[i] = '0;
         nt[i] = '0;
      end
      step(3);
      chk("reset_gnt",  32'(gnt),  0);
      chk("reset_done", 32'(done), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_tick", 32'(tick), 0);
      reset_n = 1'b1;
      step(2);

      // Single request, F=3, N=2
      fv[0] = 8'd3; nt[0] = 8'd2; req = 4'b0001;
      step(1); chk("t1_gnt_c1", 32'(gnt), 32'h1); chk("t1_busy_c1", 32'(busy), 1);
      step(3); chk("t1_tick_c4", 32'(tick), 1);
      step(4); chk("t1_tick_c8", 32'(tick), 1);
      step(1); chk("t1_tick_c9", 32'(tick), 0); chk("t1_done_c9", 32'(done), 0);
      step(1); chk("t1_done_c10", 32'(done), 32'h1); chk("t1_gnt_c10", 32'(gnt), 32'h1);
      req = '0;
      step(1); chk("t1_gnt_c11", 32'(gnt), 0); chk("t1_busy_c11", 32'(busy), 0);

      // Zero ticks on requester 2
      fv[2] = 8'd5; nt[2] = 8'd0; req = 4'b0100;
      step(1); chk("t2_gnt_c1", 32'(gnt), 32'h4); chk("t2_tick_c1", 32'(tick), 0);
      step(1); chk("t2_done_c2", 32'(done), 32'h4);
      req = '0;
      step(1); chk("t2_busy_c3", 32'(busy), 0);

      // Round-robin with all requests held after a fresh reset
      reset_n = 1'b0;
      step(1); chk("t3_reset_gnt", 32'(gnt), 0);
      for (int i = 0; i < NREQ; i++) begin
         fv[i] = 8'd0;
         nt[i] = 8'd1;
      end
      req = 4'b1111;
      reset_n = 1'b1;
      step(1); chk("t3_gnt_c1",  32'(gnt), 32'h1); chk("t3_tick_c1", 32'(tick), 1);
      step(4); chk("t3_gnt_c5",  32'(gnt), 32'h2);
      step(4); chk("t3_gnt_c9",  32'(gnt), 32'h4);
      step(4); chk("t3_gnt_c13", 32'(gnt), 32'h8);
      step(4); chk("t3_gnt_c17", 32'(gnt), 32'h1);
      step(2); chk("t3_done_c19", 32'(done), 32'h1);
      req = '0;
      step(1); chk("t3_busy_c20", 32'(busy), 0);

      // Inputs changed mid-service are ignored
      fv[1] = 8'd2; nt[1] = 8'd2; req = 4'b0010;
      step(1); chk("t4_gnt_c1", 32'(gnt), 32'h2);
      step(1); fv[1] = 8'd9; nt[1] = 8'd7;
      step(1); chk("t4_tick_c3", 32'(tick), 1);
      step(3); chk("t4_tick_c6", 32'(tick), 1);
      step(1); chk("t4_tick_c7", 32'(tick), 0);
      step(1); chk("t4_done_c8", 32'(done), 32'h2);
      req = '0;
      step(1); chk("t4_busy_c9", 32'(busy), 0);

      // Asynchronous reset mid-service
      fv[3] = 8'd4; nt[3] = 8'd3; req = 4'b1000;
      step(1); chk("t5_gnt_c1", 32'(gnt), 32'h8);
      step(4); chk("t5_tick_c5", 32'(tick), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_gnt",  32'(gnt),  0);
      chk("t5_rst_done", 32'(done), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_tick", 32'(tick), 0);
      fv[0] = 8'd1; nt[0] = 8'd1; req = 4'b1001;
      step(1);
      reset_n = 1'b1;
      step(1); chk("t5_first_gnt", 32'(gnt), 32'h1);
      step(3); chk("t5_done0_c4", 32'(done), 32'h1);
      req = 4'b1000;
      step(2); chk("t5_gnt3_c6", 32'(gnt), 32'h8);
      step(16); chk("t5_done3_c22", 32'(done), 32'h8);
      req = '0;
      step(1); chk("t5_busy_c23", 32'(busy), 0);

      // Requester 3 drops its request mid-RUN
      fv[3] = 8'd1; nt[3] = 8'd4; req = 4'b1000;
      step(1); chk("t6_gnt_c1", 32'(gnt), 32'h8);
      step(2); req = '0;
      step(1);
`ifdef BGEN_SCHED_ABORT_EN
      chk("t6_gnt_c4", 32'(gnt), 0);
      chk("t6_busy_c4", 32'(busy), 0);
`else
      chk("t6_gnt_c4", 32'(gnt), 32'h8);
      chk("t6_busy_c4", 32'(busy), 1);
`endif
      step(6);
`ifdef BGEN_SCHED_ABORT_EN
      chk("t6_done_c10", 32'(done), 0);
`else
      chk("t6_done_c10", 32'(done), 32'h8);
`endif
      step(1); chk("t6_busy_c11", 32'(busy), 0);

      step(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
